// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule constants, Rcon table, FSM state type,
// and word helpers used by both the key schedule and the round datapath.
package aes_pkg;

  localparam int NR        = 10;
  localparam int NUM_RKEYS = 11;

  // Round constants Rcon[1..10], stored at offsets 0..9
  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_t;

  // Rcon byte for round 1..10; any other round yields zero
  function automatic logic [7:0] rcon_byte(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h00;
    if (round >= 4'd1 && round <= 4'd10) r = RCON[round - 4'd1];
    return r;
  endfunction

  // [a0,a1,a2,a3] -> [a1,a2,a3,a0], a0 being the most significant byte
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Word i of a 128-bit block; word 0 occupies bits [127:96]
  function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] i);
    logic [31:0] w;
    case (i)
      2'd0:    w = k[127:96];
      2'd1:    w = k[95:64];
      2'd2:    w = k[63:32];
      default: w = k[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module SBox (
  input  logic [7:0] iByte,
  output logic [7:0] oByte
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the inverse of a (and maps 0 to 0, as the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
             ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  // Purely combinational substitution
  always_comb oByte = affine(gf_inv(iByte));

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: applies the S-box to each byte of a 32-bit word.
module aes_sub_word (
  input  logic [31:0] word,
  output logic [31:0] subbed
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    SBox u_sbox (
      .iByte (word[8*g +: 8]),
      .oByte (subbed[8*g +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, streamed out and
// stored in an 11-entry bank that the cipher reads by round index.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iStart,
  input  logic [127:0] iKey,
  output logic         oBusy,
  output logic [127:0] oRoundKey,
  output logic [3:0]   oRoundIdx,
  output logic         oRoundValid,
  output logic         oDone,
  output logic         oKeyReady,
  input  logic [3:0]   iRdIdx,
  output logic [127:0] oRdKey
);

  ks_state_t    state, state_next;
  logic         accept;
  logic [3:0]   ctr_p0;
  logic [127:0] w_p0;
  logic [127:0] bank [NUM_RKEYS];

  logic [127:0] round_key_p1;
  logic [3:0]   round_idx_p1;
  logic         vld_p1;
  logic         done_p1;
  logic         key_ready;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_w3;
  logic [31:0]  t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] w_next;
  logic         last_round;
  logic [127:0] rd_key;

  // ---- stage p0: working register W and next-round derivation ----
  assign w0 = key_word(w_p0, 2'd0);
  assign w1 = key_word(w_p0, 2'd1);
  assign w2 = key_word(w_p0, 2'd2);
  assign w3 = key_word(w_p0, 2'd3);

  aes_sub_word u_sub_word (
    .word   (rot_word(w3)),
    .subbed (sub_w3)
  );

  assign t          = sub_w3 ^ {rcon_byte(ctr_p0 + 4'd1), 24'h000000};
  assign n0         = w0 ^ t;
  assign n1         = w1 ^ n0;
  assign n2         = w2 ^ n1;
  assign n3         = w3 ^ n2;
  assign w_next     = {n0, n1, n2, n3};
  assign last_round = (ctr_p0 == 4'(NR));

  // FSM next state; a start is only accepted from IDLE
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          state_next = RUN;
          accept     = 1'b1;
        end
      end
      RUN: begin
        if (last_round) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= state_next;
  end

  // Working register: loaded with the key on accept, advanced until round 10
  always_ff @(posedge iClk) begin
    if (accept)                        w_p0 <= iKey;
    else if (state == RUN && !last_round) w_p0 <= w_next;
  end

  // Bank write: the key held in W during a RUN cycle is stored at its index
  always_ff @(posedge iClk) begin
    for (int i = 0; i < NUM_RKEYS; i++) begin
      if (state == RUN && ctr_p0 == 4'(i)) bank[i] <= w_p0;
    end
  end

  // ---- stage p1: registered stream outputs and schedule-ready flag ----
  // Output registers mirror W so round key k appears the cycle W holds it
  always_ff @(posedge iClk) begin
    if (iRst) begin
      ctr_p0       <= 4'd0;
      round_key_p1 <= '0;
      round_idx_p1 <= 4'd0;
      vld_p1       <= 1'b0;
      done_p1      <= 1'b0;
      key_ready    <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      if (accept) begin
        ctr_p0       <= 4'd0;
        round_key_p1 <= iKey;
        round_idx_p1 <= 4'd0;
        vld_p1       <= 1'b1;
        key_ready    <= 1'b0;
      end else if (state == RUN) begin
        if (last_round) begin
          key_ready <= 1'b1;
        end else begin
          ctr_p0       <= ctr_p0 + 4'd1;
          round_key_p1 <= w_next;
          round_idx_p1 <= ctr_p0 + 4'd1;
          vld_p1       <= 1'b1;
          done_p1      <= (ctr_p0 == 4'(NR - 1));
        end
      end
    end
  end

  // Bank read, masked until a complete schedule exists and for indices > 10
  always_comb begin
    rd_key = '0;
    if (key_ready) begin
      for (int i = 0; i < NUM_RKEYS; i++) begin
        if (iRdIdx == 4'(i)) rd_key = bank[i];
      end
    end
  end

  assign oBusy       = (state == RUN);
  assign oRoundKey   = round_key_p1;
  assign oRoundIdx   = round_idx_p1;
  assign oRoundValid = vld_p1;
  assign oDone       = done_p1;
  assign oKeyReady   = key_ready;
  assign oRdKey      = rd_key;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed testbench for the AES-128 key schedule.
module tb_aes_key_expand;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         round_valid;
  logic         done;
  logic         key_ready;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int checks = 0;
  int fails  = 0;

  logic [127:0] fips [0:10];
  logic [127:0] c1_key, c1_r1, c1_r10;
  logic [127:0] streamed [0:10];

  aes_key_expand dut (
    .iClk        (clk),
    .iRst        (rst),
    .iStart      (start),
    .iKey        (key),
    .oBusy       (busy),
    .oRoundKey   (round_key),
    .oRoundIdx   (round_idx),
    .oRoundValid (round_valid),
    .oDone       (done),
    .oKeyReady   (key_ready),
    .iRdIdx      (rd_idx),
    .oRdKey      (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    tick; tick;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (round_valid !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_valid_done got %b%b want 00", round_valid, done); end
    checks++; if (key_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", key_ready); end
    checks++; if (round_key !== 128'h0 || round_idx !== 4'd0) begin fails++; $display("FAIL reset_key got %h/%0d want 0/0", round_key, round_idx); end
  endtask

  task automatic test_read_before_done;
    for (int i = 0; i < 16; i += 5) begin
      rd_idx = 4'(i);
      #1;
      checks++; if (rd_key !== 128'h0) begin fails++; $display("FAIL early_read idx %0d got %h want 0", i, rd_key); end
    end
    rd_idx = 4'd0;
  endtask

  task automatic test_fips;
    key = fips[0]; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      checks++; if (round_valid !== 1'b1 || round_idx !== 4'(k)) begin fails++; $display("FAIL fips_valid k %0d got v=%b idx=%0d want v=1 idx=%0d", k, round_valid, round_idx, k); end
      checks++; if (round_key !== fips[k]) begin fails++; $display("FAIL fips_key k %0d got %h want %h", k, round_key, fips[k]); end
      checks++; if (done !== (k == 10) || busy !== 1'b1) begin fails++; $display("FAIL fips_done k %0d got done=%b busy=%b want done=%b busy=1", k, done, busy, (k == 10)); end
      tick;
    end
    checks++; if (key_ready !== 1'b1 || busy !== 1'b0 || round_valid !== 1'b0) begin fails++; $display("FAIL fips_end got ready=%b busy=%b valid=%b want 1 0 0", key_ready, busy, round_valid); end
  endtask

  task automatic test_c1_readback;
    key = c1_key; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      streamed[k] = round_key;
      checks++; if (round_valid !== 1'b1 || done !== (k == 10)) begin fails++; $display("FAIL c1_stream k %0d got v=%b d=%b", k, round_valid, done); end
      tick;
    end
    checks++; if (streamed[0] !== c1_key) begin fails++; $display("FAIL c1_r0 got %h want %h", streamed[0], c1_key); end
    checks++; if (streamed[1] !== c1_r1) begin fails++; $display("FAIL c1_r1 got %h want %h", streamed[1], c1_r1); end
    checks++; if (streamed[10] !== c1_r10) begin fails++; $display("FAIL c1_r10 got %h want %h", streamed[10], c1_r10); end
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i);
      #1;
      checks++; if (rd_key !== streamed[i]) begin fails++; $display("FAIL c1_read idx %0d got %h want %h", i, rd_key, streamed[i]); end
    end
    rd_idx = 4'd11; #1;
    checks++; if (rd_key !== 128'h0) begin fails++; $display("FAIL oor_read idx 11 got %h want 0", rd_key); end
    rd_idx = 4'd15; #1;
    checks++; if (rd_key !== 128'h0) begin fails++; $display("FAIL oor_read idx 15 got %h want 0", rd_key); end
    rd_idx = 4'd0;
  endtask

  task automatic test_start_while_busy;
    key = fips[0]; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      checks++; if (round_key !== fips[k] || round_idx !== 4'(k)) begin fails++; $display("FAIL busy_key k %0d got %h/%0d want %h/%0d", k, round_key, round_idx, fips[k], k); end
      if (k == 4 || k == 10) begin
        key = c1_key; start = 1'b1;
      end
      tick;
      start = 1'b0;
      key = fips[0];
    end
    checks++; if (busy !== 1'b0 || key_ready !== 1'b1) begin fails++; $display("FAIL busy_ignored got busy=%b ready=%b want 0 1", busy, key_ready); end
    rd_idx = 4'd10; #1;
    checks++; if (rd_key !== fips[10]) begin fails++; $display("FAIL busy_bank got %h want %h", rd_key, fips[10]); end
    key = c1_key; start = 1'b1;
    tick;
    start = 1'b0;
    checks++; if (key_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL restart_accept got ready=%b busy=%b want 0 1", key_ready, busy); end
    checks++; if (rd_key !== 128'h0) begin fails++; $display("FAIL restart_masked got %h want 0", rd_key); end
    checks++; if (round_key !== c1_key || round_valid !== 1'b1) begin fails++; $display("FAIL restart_r0 got %h want %h", round_key, c1_key); end
    for (int k = 1; k < 11; k++) tick;
    checks++; if (round_key !== c1_r10 || done !== 1'b1) begin fails++; $display("FAIL restart_r10 got %h d=%b want %h d=1", round_key, done, c1_r10); end
    tick;
    rd_idx = 4'd0;
  endtask

  task automatic test_reset_mid_run;
    key = fips[0]; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick;
    checks++; if (round_idx !== 4'd4) begin fails++; $display("FAIL mid_idx got %0d want 4", round_idx); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    rd_idx = 4'd0; #1;
    checks++; if (busy !== 1'b0 || round_valid !== 1'b0 || done !== 1'b0 || key_ready !== 1'b0) begin fails++; $display("FAIL mid_ctrl got b=%b v=%b d=%b r=%b want 0", busy, round_valid, done, key_ready); end
    checks++; if (round_key !== 128'h0 || round_idx !== 4'd0 || rd_key !== 128'h0) begin fails++; $display("FAIL mid_data got %h/%0d rd=%h want 0", round_key, round_idx, rd_key); end
    tick;
    checks++; if (busy !== 1'b0 || key_ready !== 1'b0) begin fails++; $display("FAIL mid_stay got b=%b r=%b want 0 0", busy, key_ready); end
    test_fips;
  endtask

  task automatic test_reset_start_collision;
    rst = 1'b1; start = 1'b1; key = c1_key;
    tick;
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0 || round_valid !== 1'b0) begin fails++; $display("FAIL collide got busy=%b valid=%b want 0 0", busy, round_valid); end
    tick;
    checks++; if (busy !== 1'b0 || key_ready !== 1'b0) begin fails++; $display("FAIL collide_after got busy=%b ready=%b want 0 0", busy, key_ready); end
  endtask

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    c1_key   = 128'h000102030405060708090a0b0c0d0e0f;
    c1_r1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    c1_r10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    rst = 1'b1; start = 1'b0; key = '0; rd_idx = 4'd0;

    test_reset;
    test_read_before_done;
    test_fips;
    test_c1_readback;
    test_start_while_busy;
    test_reset_mid_run;
    test_reset_start_collision;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
